spi_slave_byte: RTL and testbench

//  Byte-oriented SPI responder, mode 0 (CPOL=0, CPHA=0), full duplex. Serves as the far-end

---
 rtl/spi_slave_byte.sv | 157 +++++++++++++++
 tb/tb_spi_slave_byte.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_byte.sv
// Mode-0 SPI byte responder, oversampled in the CLOCK domain, with a valid/ready TX holding register.
// Optional: define SPI_SLAVE_LSB_FIRST_EN for LSB-first shifting in both directions.
module spi_slave_byte #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  DEFAULT_TX  = 8'hFF
) (
  input  logic       CLOCK,
  input  logic       RESET_N,
  input  logic       spi_sck_pin,
  input  logic       spi_ss_n_pin,
  input  logic       spi_mosi_pin,
  output logic       spi_miso_pin,
  output logic       spi_miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       tx_underrun,
  output logic       busy
);

`ifdef SPI_SLAVE_LSB_FIRST_EN
  localparam int TX_BIT = 0;
`else
  localparam int TX_BIT = 7;
`endif

  typedef enum logic {IDLE, ACTIVE} state_t;

  function automatic logic [7:0] rx_insert(input logic [7:0] cur, input logic bit_in);
`ifdef SPI_SLAVE_LSB_FIRST_EN
    return {bit_in, cur[7:1]};
`else
    return {cur[6:0], bit_in};
`endif
  endfunction

  function automatic logic [7:0] tx_advance(input logic [7:0] cur);
`ifdef SPI_SLAVE_LSB_FIRST_EN
    return {1'b0, cur[7:1]};
`else
    return {cur[6:0], 1'b0};
`endif
  endfunction

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sck_sync_p0, ss_n_sync_p0, mosi_sync_p0;
  logic                   sck_dly_p1;
  logic                   sck_s, ss_n_s, mosi_s;
  logic                   sck_rise, sck_fall;
  logic                   frame_start, frame_end;
  logic                   rx_shift_en, tx_edge, tx_shift_en, byte_load;
  logic [2:0]             bitcnt;
  logic [7:0]             rx_shift_p1, tx_shift_p1, hold_data, load_byte, rx_assembled;
  logic                   hold_full;

  // Stage p0: input synchronizers; p1: extra SCK flop for edge strobes
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      sck_sync_p0  <= '0;
      ss_n_sync_p0 <= '1;
      mosi_sync_p0 <= '0;
      sck_dly_p1   <= 1'b0;
    end else begin
      sck_sync_p0  <= {sck_sync_p0[SYNC_STAGES-2:0], spi_sck_pin};
      ss_n_sync_p0 <= {ss_n_sync_p0[SYNC_STAGES-2:0], spi_ss_n_pin};
      mosi_sync_p0 <= {mosi_sync_p0[SYNC_STAGES-2:0], spi_mosi_pin};
      sck_dly_p1   <= sck_s;
    end
  end

  assign sck_s    = sck_sync_p0[SYNC_STAGES-1];
  assign ss_n_s   = ss_n_sync_p0[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_p0[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_dly_p1;
  assign sck_fall = ~sck_s & sck_dly_p1;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    case (state)
      IDLE: begin
        if (!ss_n_s) begin
          state_nxt   = ACTIVE;
          frame_start = 1'b1;
        end
      end
      ACTIVE: begin
        if (ss_n_s) begin
          state_nxt = IDLE;
          frame_end = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A deselect in the same cycle as an SCK edge suppresses that edge.
  assign rx_shift_en  = (state == ACTIVE) && !ss_n_s && sck_rise;
  assign tx_edge      = (state == ACTIVE) && !ss_n_s && sck_fall;
  assign tx_shift_en  = tx_edge && (bitcnt != 3'd0);
  assign byte_load    = frame_start || (tx_edge && (bitcnt == 3'd0));
  assign load_byte    = hold_full ? hold_data : (tx_valid ? tx_data : DEFAULT_TX);
  assign rx_assembled = rx_insert(rx_shift_p1, mosi_s);

  assign tx_ready     = !hold_full;
  assign busy         = (state == ACTIVE);
  assign spi_miso_oe  = (state == ACTIVE);
  assign spi_miso_pin = (state == ACTIVE) ? tx_shift_p1[TX_BIT] : 1'b0;

  // Stage p1: control registers (counter, holding flag, strobes, received byte)
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      bitcnt      <= 3'd0;
      hold_full   <= 1'b0;
      rx_data     <= 8'h00;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= byte_load && !hold_full && !tx_valid;
      if (byte_load)
        hold_full <= 1'b0;
      else if (tx_valid && !hold_full)
        hold_full <= 1'b1;
      if (frame_start || frame_end) begin
        bitcnt <= 3'd0;
      end else if (rx_shift_en) begin
        bitcnt <= bitcnt + 3'd1;
        if (bitcnt == 3'd7) begin
          rx_data  <= rx_assembled;
          rx_valid <= 1'b1;
        end
      end
    end
  end

  // Stage p1: shift/holding data registers, only meaningful while qualified by control
  always_ff @(posedge CLOCK) begin
    if (!byte_load && tx_valid && !hold_full)
      hold_data <= tx_data;
    if (byte_load)
      tx_shift_p1 <= load_byte;
    else if (tx_shift_en)
      tx_shift_p1 <= tx_advance(tx_shift_p1);
    if (rx_shift_en)
      rx_shift_p1 <= rx_assembled;
  end

endmodule

// File: tb/tb_spi_slave_byte.sv
// Self-checking bench for spi_slave_byte: mode-0 master model, TX feeder and byte-level reference model.
`timescale 1ns/1ps
module tb_spi_slave_byte;

`ifdef SPI_SLAVE_LSB_FIRST_EN
  localparam bit LSB = 1'b1;
`else
  localparam bit LSB = 1'b0;
`endif

  logic       CLOCK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       spi_sck_pin = 1'b0;
  logic       spi_ss_n_pin = 1'b1;
  logic       spi_mosi_pin = 1'b0;
  logic       spi_miso_pin, spi_miso_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, tx_underrun, busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] tx_q[$];
  logic [7:0] mosi_q[$];
  logic [7:0] rx_got[$];
  logic [7:0] miso_got[$];
  int         underruns = 0;
  bit         hs_next = 1'b0;
  logic       first_miso_bit;

  spi_slave_byte #(.SYNC_STAGES(2), .DEFAULT_TX(8'hFF)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N),
    .spi_sck_pin(spi_sck_pin), .spi_ss_n_pin(spi_ss_n_pin), .spi_mosi_pin(spi_mosi_pin),
    .spi_miso_pin(spi_miso_pin), .spi_miso_oe(spi_miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun), .busy(busy)
  );

  always #5 CLOCK = ~CLOCK;

  // Local-side monitor.
  always @(negedge CLOCK) begin
    if (RESET_N) begin
      if (rx_valid) rx_got.push_back(rx_data);
      if (tx_underrun) underruns++;
    end
  end

  // TX feeder: offers the head of tx_q; a handshake seen at a negedge completes at the next posedge.
  always @(negedge CLOCK) begin
    if (hs_next && tx_q.size() > 0) void'(tx_q.pop_front());
    tx_valid = RESET_N && (tx_q.size() > 0);
    tx_data  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
    hs_next  = tx_valid && tx_ready;
  end

  function automatic int bit_idx(input int bi);
    return LSB ? bi : 7 - bi;
  endfunction

  // Mode-0 master at f_CLOCK/8. A whole-byte frame ends with SS_N rising together with the last SCK fall.
  task automatic run_frame(input int nbits);
    logic [7:0] mo, mi;
    int bi;
    mo = 8'h00;
    mi = 8'h00;
    rx_got.delete();
    miso_got.delete();
    underruns = 0;
    @(negedge CLOCK) spi_ss_n_pin = 1'b0;
    repeat (8) @(negedge CLOCK);
    for (int b = 0; b < nbits; b++) begin
      bi = b % 8;
      if (bi == 0) begin
        mo = mosi_q[b / 8];
        mi = 8'h00;
      end
      spi_mosi_pin = mo[bit_idx(bi)];
      repeat (4) @(negedge CLOCK);
      mi[bit_idx(bi)] = spi_miso_pin;
      if (b == 0) first_miso_bit = spi_miso_pin;
      spi_sck_pin = 1'b1;
      if (bi == 7) miso_got.push_back(mi);
      repeat (4) @(negedge CLOCK);
      spi_sck_pin = 1'b0;
      if (b == nbits - 1 && (nbits % 8) == 0) spi_ss_n_pin = 1'b1;
    end
    if ((nbits % 8) != 0) begin
      repeat (4) @(negedge CLOCK);
      spi_ss_n_pin = 1'b1;
    end
    repeat (12) @(negedge CLOCK);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge CLOCK);
    checks++; if (spi_miso_pin !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b want 0", spi_miso_pin); end
    checks++; if (spi_miso_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", spi_miso_oe); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    checks++; if (tx_underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun: got %b want 0", tx_underrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    RESET_N = 1'b1;
    repeat (4) @(negedge CLOCK);
  endtask

  task automatic test_single_byte;
    tx_q.push_back(8'hA5);
    repeat (6) @(negedge CLOCK);
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL single_hold_full: tx_ready got %b want 0", tx_ready); end
    mosi_q = '{8'h3C};
    run_frame(8);
    checks++; if (miso_got.size() != 1 || miso_got[0] !== 8'hA5) begin errors++; $display("FAIL single_miso: got %h want a5", (miso_got.size() > 0) ? miso_got[0] : 8'hxx); end
    checks++; if (rx_got.size() != 1) begin errors++; $display("FAIL single_rx_pulses: got %0d want 1", rx_got.size()); end
    checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL single_rx_data: got %h want 3c", rx_data); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL single_tx_ready: got %b want 1", tx_ready); end
    checks++; if (underruns != 0) begin errors++; $display("FAIL single_underrun: got %0d want 0", underruns); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b want 0", busy); end
  endtask

  task automatic test_multi_byte;
    logic [7:0] exp_tx[3];
    exp_tx = '{8'h10, 8'h20, 8'h30};
    for (int i = 0; i < 3; i++) tx_q.push_back(exp_tx[i]);
    repeat (6) @(negedge CLOCK);
    mosi_q = '{8'h01, 8'h02, 8'h03};
    run_frame(24);
    checks++; if (rx_got.size() != 3 || miso_got.size() != 3) begin errors++; $display("FAIL multi_count: rx %0d miso %0d want 3/3", rx_got.size(), miso_got.size()); end
    for (int i = 0; i < 3 && i < rx_got.size() && i < miso_got.size(); i++) begin
      checks++; if (miso_got[i] !== exp_tx[i]) begin errors++; $display("FAIL multi_miso[%0d]: got %h want %h", i, miso_got[i], exp_tx[i]); end
      checks++; if (rx_got[i] !== mosi_q[i]) begin errors++; $display("FAIL multi_rx[%0d]: got %h want %h", i, rx_got[i], mosi_q[i]); end
    end
    checks++; if (underruns != 0) begin errors++; $display("FAIL multi_underrun: got %0d want 0", underruns); end
  endtask

  task automatic test_underrun;
    mosi_q = '{8'h00};
    run_frame(8);
    checks++; if (miso_got.size() != 1 || miso_got[0] !== 8'hFF) begin errors++; $display("FAIL underrun_miso: got %h want ff", (miso_got.size() > 0) ? miso_got[0] : 8'hxx); end
    checks++; if (underruns != 1) begin errors++; $display("FAIL underrun_pulses: got %0d want 1", underruns); end
    checks++; if (rx_got.size() != 1 || rx_data !== 8'h00) begin errors++; $display("FAIL underrun_rx: got %h (%0d pulses) want 00", rx_data, rx_got.size()); end
  endtask

  task automatic test_abort;
    mosi_q = '{8'hB7};
    run_frame(5);
    checks++; if (rx_got.size() != 0) begin errors++; $display("FAIL abort_rx_valid: got %0d pulses want 0", rx_got.size()); end
    checks++; if (busy !== 1'b0 || spi_miso_oe !== 1'b0) begin errors++; $display("FAIL abort_idle: busy %b oe %b want 0 0", busy, spi_miso_oe); end
    mosi_q = '{8'h81};
    run_frame(8);
    checks++; if (rx_got.size() != 1 || rx_data !== 8'h81) begin errors++; $display("FAIL abort_next_rx: got %h (%0d pulses) want 81", rx_data, rx_got.size()); end
  endtask

  task automatic test_reset_midframe;
    tx_q.push_back(8'h11);
    tx_q.push_back(8'h22);
    repeat (6) @(negedge CLOCK);
    spi_ss_n_pin = 1'b0;
    repeat (8) @(negedge CLOCK);
    for (int b = 0; b < 3; b++) begin
      spi_mosi_pin = 1'b1;
      repeat (4) @(negedge CLOCK);
      spi_sck_pin = 1'b1;
      repeat (4) @(negedge CLOCK);
      spi_sck_pin = 1'b0;
    end
    checks++; if (busy !== 1'b1 || spi_miso_oe !== 1'b1) begin errors++; $display("FAIL midreset_active: busy %b oe %b want 1 1", busy, spi_miso_oe); end
    @(posedge CLOCK);
    #2;
    tx_q.delete();
    hs_next  = 1'b0;
    tx_valid = 1'b0;
    RESET_N  = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || spi_miso_oe !== 1'b0 || spi_miso_pin !== 1'b0) begin errors++; $display("FAIL midreset_frame: busy %b oe %b miso %b want 0 0 0", busy, spi_miso_oe, spi_miso_pin); end
    checks++; if (tx_ready !== 1'b1 || rx_data !== 8'h00 || rx_valid !== 1'b0 || tx_underrun !== 1'b0) begin errors++; $display("FAIL midreset_local: ready %b rx %h rxv %b und %b want 1 00 0 0", tx_ready, rx_data, rx_valid, tx_underrun); end
    spi_ss_n_pin = 1'b1;
    spi_mosi_pin = 1'b0;
    repeat (3) @(negedge CLOCK);
    RESET_N = 1'b1;
    repeat (6) @(negedge CLOCK);
  endtask

  task automatic test_lsb_first;
    tx_q.push_back(8'h01);
    repeat (6) @(negedge CLOCK);
    mosi_q = '{8'h01};
    run_frame(8);
    checks++; if (first_miso_bit !== (LSB ? 1'b1 : 1'b0)) begin errors++; $display("FAIL order_first_bit: got %b want %b", first_miso_bit, LSB); end
    checks++; if (rx_got.size() != 1 || rx_data !== 8'h01) begin errors++; $display("FAIL order_rx: got %h want 01", rx_data); end
  endtask

  // Randomized frames: the master reads the supplied bytes in order, then DEFAULT_TX once per empty load.
  task automatic test_random;
    int len, sup;
    logic [7:0] txb[4];
    logic [7:0] exp_miso;
    for (int f = 0; f < 8; f++) begin
      len = $urandom_range(1, 4);
      sup = $urandom_range(0, len);
      mosi_q.delete();
      for (int i = 0; i < len; i++) begin
        mosi_q.push_back(8'($urandom));
        txb[i] = 8'($urandom);
        if (i < sup) tx_q.push_back(txb[i]);
      end
      repeat ($urandom_range(2, 8)) @(negedge CLOCK);
      run_frame(len * 8);
      checks++; if (rx_got.size() != len || miso_got.size() != len) begin errors++; $display("FAIL rand%0d_count: rx %0d miso %0d want %0d", f, rx_got.size(), miso_got.size(), len); end
      for (int i = 0; i < len && i < rx_got.size() && i < miso_got.size(); i++) begin
        exp_miso = (i < sup) ? txb[i] : 8'hFF;
        checks++; if (miso_got[i] !== exp_miso) begin errors++; $display("FAIL rand%0d_miso[%0d]: got %h want %h", f, i, miso_got[i], exp_miso); end
        checks++; if (rx_got[i] !== mosi_q[i]) begin errors++; $display("FAIL rand%0d_rx[%0d]: got %h want %h", f, i, rx_got[i], mosi_q[i]); end
      end
      checks++; if (underruns != len - sup) begin errors++; $display("FAIL rand%0d_underrun: got %0d want %0d", f, underruns, len - sup); end
      checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rand%0d_tx_ready: got %b want 1", f, tx_ready); end
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_multi_byte();
    test_underrun();
    test_abort();
    test_reset_midframe();
    test_lsb_first();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
